// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback: register-ID decode, 15x64 register file with
// combinational reads, condition-code register and RUN/HALT tracking.
module decode_writeback #(
  parameter int         DATA_W   = 64,
  parameter logic [3:0] RSP_ID   = 4'h4,
  parameter logic [3:0] NONE_ID  = 4'hF,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              cnd,
  input  logic [2:0]        cf_out,
  input  logic              wb_en,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [2:0]        cf_in,
  output logic              halted,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [15];
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic              stop_instr;

  // ID 4'hF is not backed by storage and always reads as zero.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] id);
    rd_reg = (id == NONE_ID || id == 4'hF) ? '0 : regs[id];
  endfunction

  always_comb begin
    src_a = NONE_ID;
    src_b = NONE_ID;
    dst_e = NONE_ID;
    dst_m = NONE_ID;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = rA;
      4'h9, 4'hB:             src_a = RSP_ID;
      default:                src_a = NONE_ID;
    endcase
    case (icode)
      4'h4, 4'h5, 4'h6:       src_b = rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP_ID;
      default:                src_b = NONE_ID;
    endcase
    case (icode)
      4'h2:                   dst_e = cnd ? rB : NONE_ID;
      4'h3, 4'h6:             dst_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP_ID;
      default:                dst_e = NONE_ID;
    endcase
    case (icode)
      4'h5, 4'hB:             dst_m = rA;
      default:                dst_m = NONE_ID;
    endcase
  end

  assign stop_instr = (icode == 4'h0) || (icode >= 4'hC);

  assign valA     = rd_reg(src_a);
  assign valB     = rd_reg(src_b);
  assign dbg_data = rd_reg(dbg_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
      cf_in  <= CC_RESET;
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else if (state == RUN && wb_en) begin
      if (dst_e != NONE_ID && dst_e != 4'hF) regs[dst_e] <= valE;
      // Issued after the valE write so valM takes precedence when dstE == dstM.
      if (dst_m != NONE_ID && dst_m != 4'hF) regs[dst_m] <= valM;
      if (icode == 4'h6) cf_in <= cf_out;
      if (stop_instr) begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end
  end

endmodule
